// File: rtl/apuf_pkg.sv
// Shared types and defaults for the arbiter-PUF evaluation controller.
//   state_t   : controller state encoding
//   DEF_*     : default parameter values
//   majority(): response decision from a ones count over an odd vote count
package apuf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        FIRE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam int DEF_N_STAGES   = 64;
    localparam int DEF_REPS       = 7;
    localparam int DEF_SETUP_CYC  = 4;
    localparam int DEF_SETTLE_CYC = 8;
    localparam int DEF_CNT_W      = 8;

    // Strict majority; REPS is odd so there is never a tie.
    function automatic logic majority(input int ones, input int reps);
        return ones > (reps / 2);
    endfunction

endpackage

// File: rtl/apuf_resp_sync.sv
// Two-flop synchroniser for the free-running arbiter output.
//   clk, rst_n : system clock, async active-low reset (flops clear to 0)
//   i_d        : asynchronous input
//   o_q        : synchronised output, two clk cycles of latency
module apuf_resp_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE" *) logic r_meta;
    (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE" *) logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/apuf_eval_ctrl.sv
// Arbiter-PUF evaluation sequencer: accepts a challenge, runs REPS
// clear/launch/settle/sample evaluations on the switch chain and returns a
// majority-voted response bit with the raw ones count.
//   clk, rst_n           : system clock, async active-low reset
//   ch_valid/ch_ready    : challenge handshake, ch_data = challenge bits
//   puf_c                : challenge held on the stage select inputs
//   puf_launch           : race edge into both chain inputs
//   puf_arb_clr          : holds the arbiter cleared
//   puf_arb_out          : raw arbiter output (asynchronous)
//   rsp_valid/rsp_ready  : response handshake, rsp_bit / rsp_ones payload
//   busy                 : controller not in IDLE
module apuf_eval_ctrl
    import apuf_pkg::*;
#(
    parameter int N_STAGES   = DEF_N_STAGES,
    parameter int REPS       = DEF_REPS,
    parameter int SETUP_CYC  = DEF_SETUP_CYC,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ch_valid,
    output logic                      ch_ready,
    input  logic [N_STAGES-1:0]       ch_data,
    output logic [N_STAGES-1:0]       puf_c,
    output logic                      puf_launch,
    output logic                      puf_arb_clr,
    input  logic                      puf_arb_out,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_bit,
    output logic [$clog2(REPS+1)-1:0] rsp_ones,
    output logic                      busy
);

    localparam int OW = $clog2(REPS + 1);

    state_t              r_state;
    logic [CNT_W-1:0]    r_tmr;
    logic [OW-1:0]       r_rep_cnt;
    logic [OW-1:0]       r_ones_cnt;
    logic                r_ch_ready;
    logic [N_STAGES-1:0] r_puf_c;
    logic                r_launch;
    logic                r_arb_clr;
    logic                r_rsp_valid;
    logic                r_rsp_bit;
    logic [OW-1:0]       r_rsp_ones;
    logic                r_busy;

    logic                w_arb_sync;
    logic [OW-1:0]       w_ones_nxt;

    apuf_resp_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (puf_arb_out),
        .o_q   (w_arb_sync)
    );

    assign w_ones_nxt = r_ones_cnt + OW'(w_arb_sync);

    // Outputs are registered on the transition into the state that owns
    // them, so launch is high for FIRE + SETTLE_CYC cycles and low again in
    // SAMPLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_tmr       <= '0;
            r_rep_cnt   <= '0;
            r_ones_cnt  <= '0;
            r_ch_ready  <= 1'b1;
            r_puf_c     <= '0;
            r_launch    <= 1'b0;
            r_arb_clr   <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_bit   <= 1'b0;
            r_rsp_ones  <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (ch_valid) begin
                        r_puf_c    <= ch_data;
                        r_ones_cnt <= '0;
                        r_rep_cnt  <= '0;
                        r_tmr      <= '0;
                        r_ch_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (r_tmr == CNT_W'(SETUP_CYC - 1)) begin
                        r_tmr     <= '0;
                        r_launch  <= 1'b1;
                        r_arb_clr <= 1'b0;
                        r_state   <= FIRE;
                    end else begin
                        r_tmr <= r_tmr + CNT_W'(1);
                    end
                end
                FIRE: begin
                    r_tmr   <= '0;
                    r_state <= SETTLE;
                end
                SETTLE: begin
                    if (r_tmr == CNT_W'(SETTLE_CYC - 1)) begin
                        r_tmr     <= '0;
                        r_launch  <= 1'b0;
                        r_arb_clr <= 1'b1;
                        r_state   <= SAMPLE;
                    end else begin
                        r_tmr <= r_tmr + CNT_W'(1);
                    end
                end
                SAMPLE: begin
                    r_ones_cnt <= w_ones_nxt;
                    r_rep_cnt  <= r_rep_cnt + OW'(1);
                    if (r_rep_cnt == OW'(REPS - 1)) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_bit   <= majority(32'(w_ones_nxt), REPS);
                        r_rsp_ones  <= w_ones_nxt;
                        r_state     <= DONE;
                    end else begin
                        r_state <= SETUP;
                    end
                end
                DONE: begin
                    // Result fields persist after the handshake.
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_ch_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ch_ready    = r_ch_ready;
    assign puf_c       = r_puf_c;
    assign puf_launch  = r_launch;
    assign puf_arb_clr = r_arb_clr;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_bit     = r_rsp_bit;
    assign rsp_ones    = r_rsp_ones;
    assign busy        = r_busy;

endmodule

// File: tb/tb_apuf_eval_ctrl.sv
// Scoreboard bench: stimulus pushes expected responses, a negedge monitor
// pops and compares on every response handshake. A second instance covers
// the single-evaluation configuration.
module tb_apuf_eval_ctrl;

    localparam int REPS = 7;
    localparam int LAT  = 98;
    localparam int LAT1 = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    // default instance
    logic        ch_valid, ch_ready, puf_launch, puf_arb_clr, puf_arb_out;
    logic        rsp_valid, rsp_ready, rsp_bit, busy;
    logic [63:0] ch_data, puf_c;
    logic [2:0]  rsp_ones;

    // REPS=1 instance
    logic        ch_valid1, ch_ready1, launch1, arb_clr1, arb1;
    logic        rsp_valid1, rsp_ready1, rsp_bit1, busy1;
    logic [63:0] ch_data1, puf_c1;
    logic [0:0]  rsp_ones1;

    apuf_eval_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ch_valid(ch_valid), .ch_ready(ch_ready),
        .ch_data(ch_data), .puf_c(puf_c), .puf_launch(puf_launch),
        .puf_arb_clr(puf_arb_clr), .puf_arb_out(puf_arb_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_bit(rsp_bit),
        .rsp_ones(rsp_ones), .busy(busy)
    );

    apuf_eval_ctrl #(.REPS(1), .SETUP_CYC(1), .SETTLE_CYC(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .ch_valid(ch_valid1), .ch_ready(ch_ready1),
        .ch_data(ch_data1), .puf_c(puf_c1), .puf_launch(launch1),
        .puf_arb_clr(arb_clr1), .puf_arb_out(arb1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_bit(rsp_bit1),
        .rsp_ones(rsp_ones1), .busy(busy1)
    );

    typedef struct {
        logic [63:0] ch;
        bit          trace;
        int          ones;
        bit          b;
    } exp_t;

    exp_t q[$];
    int   q1[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    logic [6:0] cur_bits;
    int         arb_idx;
    bit         toggle_mode;
    logic       s1 = 1'b0, s2 = 1'b0;
    int         tr_ones = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Bench-side synchroniser trace: the arbiter input only moves 1..8 ns
    // after a rising edge, so sampling it at the edge is race-free.
    initial forever begin
        @(posedge clk);
        s2 = s1;
        s1 = puf_arb_out;
    end

    // Arbiter model: on each launch rising edge present the next scripted
    // bit; in toggle mode also flip randomly at a random phase each cycle.
    initial begin
        logic lp;
        lp = 1'b0;
        puf_arb_out = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (puf_launch && !lp && arb_idx < 7) begin
                puf_arb_out = cur_bits[arb_idx];
                arb_idx++;
            end
            lp = puf_launch;
            if (toggle_mode) begin
                #($urandom_range(0, 7));
                puf_arb_out = 1'($urandom);
            end
        end
    end

    // Monitor / scoreboard
    int   acc_edge = 0, nrise = 0, hi = 0, acc1 = 0;
    bit   ln_prev = 1'b0, rv_d = 1'b0, rv1_d = 1'b0;
    exp_t e;
    int   e1;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            nrise = 0;
            hi    = 0;
        end else begin
            if (ch_valid && ch_ready) begin
                acc_edge = cyc + 1;
                nrise    = 0;
                tr_ones  = 0;
            end
            if (puf_launch) begin
                if (hi == 0) nrise++;
                hi++;
            end else if (hi != 0) begin
                chk("launch_high_cycles", hi, 9);
                hi = 0;
            end
            if (!puf_launch && ln_prev) tr_ones += int'(s2);
            if (busy && q.size() > 0) chk("puf_c_held", puf_c, q[0].ch);
            if (rsp_valid && !rv_d) begin
                chk("latency", cyc - acc_edge, LAT);
                chk("launch_pulses", nrise, REPS);
            end
            if (rsp_valid && rsp_ready) begin
                chk("rsp_expected", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("rsp_bit_known", $isunknown(rsp_bit), 0);
                    if (e.trace) begin
                        chk("trace_ones", rsp_ones, tr_ones);
                        chk("trace_bit", rsp_bit, tr_ones > REPS / 2);
                    end else begin
                        chk("rsp_ones", rsp_ones, e.ones);
                        chk("rsp_bit", rsp_bit, e.b);
                    end
                end
            end
            if (ch_valid1 && ch_ready1) acc1 = cyc + 1;
            if (rsp_valid1 && !rv1_d) chk("latency_reps1", cyc - acc1, LAT1);
            if (rsp_valid1 && rsp_ready1) begin
                chk("rsp1_expected", q1.size() > 0, 1);
                if (q1.size() > 0) begin
                    e1 = q1.pop_front();
                    chk("rsp1_ones", rsp_ones1, e1);
                    chk("rsp1_bit", rsp_bit1, e1);
                end
            end
        end
        ln_prev = puf_launch;
        rv_d    = rsp_valid;
        rv1_d   = rsp_valid1;
    end

    task automatic send(input logic [63:0] ch, input logic [6:0] bits,
                        input bit trace, output int waits);
        exp_t x;
        int   n;
        n        = 0;
        cur_bits = bits;
        arb_idx  = 0;
        x.ch     = ch;
        x.trace  = trace;
        x.ones   = $countones(bits);
        x.b      = (x.ones > REPS / 2);
        ch_data  = ch;
        ch_valid = 1'b1;
        while (!ch_ready && n < 300) begin
            tick;
            n++;
        end
        if (!ch_ready) chk("accept_timeout", ch_ready, 1);
        else begin
            tick;
            q.push_back(x);
        end
        ch_valid = 1'b0;
        waits    = n;
    endtask

    task automatic wait_rsp(input int hold);
        int n;
        n = 0;
        while (!rsp_valid && n < 400) begin
            tick;
            n++;
        end
        if (!rsp_valid) chk("rsp_timeout", rsp_valid, 1);
        else begin
            if (hold > 0) begin
                rsp_ready = 1'b0;
                repeat (hold) tick;
                rsp_ready = 1'b1;
            end
            tick;
            chk("done_released", rsp_valid, 0);
        end
    endtask

    task automatic send1(input bit b);
        int n;
        n         = 0;
        arb1      = b;
        ch_data1  = {$urandom, $urandom};
        ch_valid1 = 1'b1;
        while (!ch_ready1 && n < 50) begin
            tick;
            n++;
        end
        if (!ch_ready1) chk("accept1_timeout", ch_ready1, 1);
        else begin
            tick;
            q1.push_back(int'(b));
        end
        ch_valid1 = 1'b0;
        n = 0;
        while (busy1 && n < 50) begin
            tick;
            n++;
        end
        chk("done1", busy1, 0);
    endtask

    initial begin
        int         w, nr, n;
        logic       lpv;
        logic [6:0] bits;
        rst_n = 1'b0;
        ch_valid = 1'b0; ch_data = '0; rsp_ready = 1'b1;
        ch_valid1 = 1'b0; ch_data1 = '0; arb1 = 1'b0; rsp_ready1 = 1'b1;
        toggle_mode = 1'b0; cur_bits = '0; arb_idx = 0;
        repeat (3) tick;
        chk("rst_ch_ready", ch_ready, 1);
        chk("rst_puf_c", puf_c, 0);
        chk("rst_launch", puf_launch, 0);
        chk("rst_arb_clr", puf_arb_clr, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_bit", rsp_bit, 0);
        chk("rst_rsp_ones", rsp_ones, 0);
        chk("rst_busy", busy, 0);
        chk("rst1_ch_ready", ch_ready1, 1);
        rst_n = 1'b1;
        tick;

        // constant arbiter and majority edges
        send(64'hA5A5_0000_FFFF_1234, 7'h7F, 1'b0, w);
        wait_rsp(0);
        send({$urandom, $urandom}, 7'b0010101, 1'b0, w);
        wait_rsp(0);
        send({$urandom, $urandom}, 7'b1010101, 1'b0, w);
        wait_rsp(0);

        // random challenges, bit patterns and response stalls
        for (int i = 0; i < 8; i++) begin
            send({$urandom, $urandom}, 7'($urandom), 1'b0, w);
            wait_rsp(int'($urandom_range(0, 4)));
        end

        // backpressure
        bits = 7'($urandom);
        rsp_ready = 1'b0;
        send({$urandom, $urandom}, bits, 1'b0, w);
        n = 0;
        while (!rsp_valid && n < 400) begin
            tick;
            n++;
        end
        for (int i = 0; i < 20; i++) begin
            chk("bp_valid", rsp_valid, 1);
            chk("bp_ones", rsp_ones, $countones(bits));
            chk("bp_bit", rsp_bit, $countones(bits) > REPS / 2);
            chk("bp_ch_ready", ch_ready, 0);
            if (i == 5) begin
                ch_data  = {$urandom, $urandom};
                ch_valid = 1'b1;
            end
            if (i == 6) ch_valid = 1'b0;
            tick;
        end
        rsp_ready = 1'b1;
        send({$urandom, $urandom}, 7'($urandom), 1'b0, w);
        chk("bp_accept_next_cycle", w, 1);
        wait_rsp(0);

        // reset during SETTLE of rep 3
        send({$urandom, $urandom}, 7'h7F, 1'b0, w);
        nr = 0; n = 0; lpv = 1'b0;
        while (nr < 4 && n < 300) begin
            tick;
            n++;
            if (puf_launch && !lpv) nr++;
            lpv = puf_launch;
        end
        chk("midrun_reached_rep3", nr, 4);
        repeat (3) tick;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_arb_clr", puf_arb_clr, 1);
        chk("midrst_launch", puf_launch, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_ch_ready", ch_ready, 1);
        q.delete();
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        send({$urandom, $urandom}, 7'b1010101, 1'b0, w);
        wait_rsp(0);

        // asynchronous arbiter toggling at random phase
        toggle_mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send({$urandom, $urandom}, 7'h00, 1'b1, w);
            wait_rsp(0);
        end
        toggle_mode = 1'b0;

        // single-evaluation configuration
        for (int i = 0; i < 6; i++) send1(1'($urandom));

        repeat (3) tick;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apuf_eval_ctrl.md
Name: apuf_eval_ctrl

Overview:
- Sequences one arbiter-PUF evaluation per accepted challenge.
- Per challenge: latches the challenge onto the switch-chain select inputs, clears the arbiter, launches the race edge, waits for the result to settle, then samples the synchronised arbiter output.
- Repeats this REPS times and returns a majority-voted response bit plus the raw ones-count, for use as a reliability metric.
- Sits between the host/UART challenge interface and the switch-chain/arbiter instance.

Parameters:
- N_STAGES, 64, challenge width = number of switch stages.
- REPS, 7, evaluations per challenge; odd, 1..255.
- SETUP_CYC, 4, cycles from challenge/clear application to launch; >=1.
- SETTLE_CYC, 8, cycles from launch to sample; >=3, so it covers the synchroniser latency.
- CNT_W, 8, width of the timing counter; must hold max(SETUP_CYC, SETTLE_CYC).

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- ch_valid, in, 1, challenge offered.
- ch_ready, out, 1, controller can accept a challenge.
- ch_data, in, N_STAGES, challenge bits.
- puf_c, out, N_STAGES, registered challenge driven to the switch-stage select inputs.
- puf_launch, out, 1, race launch; drives the top and bottom chain inputs.
- puf_arb_clr, out, 1, holds the arbiter cleared.
- puf_arb_out, in, 1, raw arbiter output; asynchronous to clk.
- rsp_valid, out, 1, result available.
- rsp_ready, in, 1, consumer accepts the result.
- rsp_bit, out, 1, majority response.
- rsp_ones, out, $clog2(REPS+1), number of evaluations that returned 1.
- busy, out, 1, high in any state except IDLE.

Behaviour:
Reset (async, rst_n=0):
- State returns to IDLE.
- Output values: ch_ready=1, puf_c=0, puf_launch=0, puf_arb_clr=1, rsp_valid=0, rsp_bit=0, rsp_ones=0, busy=0.
- All counters are cleared.
- Reset mid-evaluation aborts the evaluation; no partial result is ever presented.

State machine:
- IDLE
  - ch_ready=1 and puf_arb_clr=1.
  - On ch_valid & ch_ready: register ch_data into puf_c, clear ones_cnt and rep_cnt, go to SETUP.
- SETUP
  - puf_launch=0 and puf_arb_clr=1. Timer counts SETUP_CYC cycles, then go to FIRE.
- FIRE
  - One cycle: puf_arb_clr drops to 0, puf_launch rises to 1. Go to SETTLE.
- SETTLE
  - puf_launch stays 1 for SETTLE_CYC cycles, then go to SAMPLE.
- SAMPLE
  - One cycle. Add the synchronised arbiter bit to ones_cnt, drive puf_launch=0 and puf_arb_clr=1, increment rep_cnt.
  - If rep_cnt reaches REPS: go to DONE. Otherwise go back to SETUP.
- DONE
  - rsp_valid=1; rsp_bit = (ones_cnt > REPS/2); rsp_ones = ones_cnt.
  - These outputs are registered and held stable until the handshake completes.
  - On rsp_valid & rsp_ready: go to IDLE with rsp_valid=0 next cycle. The rsp_bit and rsp_ones values persist.

Handshake and timing rules:
- ch_ready=1 only in IDLE. A challenge offered while busy is not consumed.
- puf_c changes only on an IDLE accept, so the challenge is constant across all REPS evaluations.
- puf_launch rises exactly once per evaluation. Its low time between evaluations is >= SETUP_CYC+1 cycles.
- Latency from accept to rsp_valid = REPS*(SETUP_CYC+1+SETTLE_CYC+1) cycles. With defaults: 7*14 = 98 cycles.
- Back-to-back operation: after the DONE handshake, IDLE accepts on the following cycle. There is no same-cycle DONE->accept.
- rsp_ready held high while rsp_valid rises gives a one-cycle DONE.
- REPS=1 gives a single evaluation: rsp_bit equals the sampled bit and rsp_ones is 0 or 1.
- puf_arb_out metastability is handled only by the 2-flop synchroniser. The sample taken in SAMPLE is the synchroniser output.

Decomposition:
- Package apuf_pkg:
  - state enum: IDLE, SETUP, FIRE, SETTLE, SAMPLE, DONE;
  - default parameter constants;
  - function majority(ones, reps).
- Sub-module apuf_resp_sync:
  - 2-flop synchroniser with async active-low reset to 0;
  - DONT_TOUCH/ASYNC_REG attributes on its flops.

Test Plan:
1. Reset mid-run: assert rst_n=0 during SETTLE of rep 3 -> immediate busy=0, puf_arb_clr=1, puf_launch=0, rsp_valid=0. The next challenge is processed from rep 0.
2. Constant arbiter: ch_data=64'hA5A5_0000_FFFF_1234, puf_arb_out=1 -> rsp_valid exactly 98 cycles after accept, rsp_bit=1, rsp_ones=7, puf_c=64'hA5A5_0000_FFFF_1234 throughout, 7 launch pulses each 9 cycles high.
3. Majority edge: arbiter model returns 1,0,1,0,1,0,0 -> rsp_ones=3, rsp_bit=0. Returning 1,0,1,0,1,0,1 -> rsp_ones=4, rsp_bit=1.
4. Backpressure: rsp_ready=0 for 20 cycles -> rsp_valid, rsp_bit and rsp_ones stable, ch_ready=0, a ch_valid pulse is ignored. Then rsp_ready=1 -> IDLE next cycle, and a held ch_valid is accepted on that cycle.
5. REPS=1, SETUP_CYC=1, SETTLE_CYC=3 -> latency 6 cycles, rsp_ones equals the single sample.
6. Async arbiter toggling near the sample edge (random phase) -> no X on rsp_bit, and the ones count is consistent with the synchroniser output trace.
